rv_main_control: RTL and testbench
==================================

Name: rv_main_control

Overview:
- Registered main-control decoder for an RV32I-subset single-issue core, placed between instruction fetch/decode and the execute datapath.
- Decodes opcode, funct3 and funct7 bit 5 into datapath control strobes and a 2-bit ALUOp for the downstream ALU-control block.
- Outputs are registered, so they are valid one cycle after the instruction is presented.
- Illegal encodings produce a NOP bundle plus an illegal flag.

Parameters:
- RESET_ALUOP, 2'b00, ALUOp value driven during and after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  instruction fields are valid this cycle.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30]; may be X for non-R/non-shift formats.
- RegWrite  out  1  write rd.
- ALUSrc  out  1  ALU operand B: 1 = immediate, 0 = rs2.
- MemRead  out  1  data-memory load.
- MemWrite  out  1  data-memory store.
- MemtoReg  out  1  writeback mux: 1 = load data, 0 = ALU result.
- Branch  out  1  conditional branch.
- ALUOp  out  2  00 = add, 01 = branch compare (sub), 10 = R-type funct decode, 11 = I-type funct decode.
- Illegal  out  1  unsupported or illegal encoding.
- valid_out  out  1  registered valid_in.

Behaviour:
- Registered decode with 1-cycle latency. Inputs sampled at edge N appear on outputs after edge N.
- On reset: every output is 0, ALUOp = RESET_ALUOP, valid_out = 0. Reset wins over valid_in in the same cycle.
- If valid_in = 0, the next cycle drives a NOP bundle: all strobes 0, ALUOp 00, Illegal 0, valid_out 0.
- Decode table, in order RW AS MR MW M2R BR ALUOp:
  - R-type 0110011: 1 0 0 0 0 0 10.
  - I-ALU 0010011: 1 1 0 0 0 0 11.
  - Load 0000011: 1 1 1 0 1 0 00.
  - Store 0100011: 0 1 0 1 0 0 00.
  - Branch 1100011: 0 0 0 0 0 1 01.
- Don't-care fields are driven 0. M2R is 0 for store and branch.
- Legality checks:
  - Load and Store: only funct3 = 010 (word) is legal.
  - Branch: funct3 010 and 011 are illegal.
  - R-type: funct7_5 = 1 is legal only with funct3 000 (SUB) or 101 (SRA).
  - I-ALU: funct3 001 requires funct7_5 = 0. funct3 101 accepts either value of funct7_5. Other funct3 values ignore funct7_5.
- Any other opcode is illegal.
- Illegal handling: all strobes 0, ALUOp 00, Illegal 1, valid_out 1.
- X safety: funct7_5 must not be referenced for Load, Store or Branch. An X on it must never reach the outputs for those formats.
- Back-to-back valid instructions are decoded every cycle with no bubbles.
- A reset mid-stream discards the in-flight decode.

Decomposition:
- Shared package (rv_pkg) holds:
  - opcode localparams OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALUOp encodings ALUOP_ADD, ALUOP_BR, ALUOP_R, ALUOP_I;
  - a packed struct ctrl_t bundling the seven control fields.
- One natural sub-module: rv_ctrl_decode_comb, purely combinational decode plus legality check. The top module adds the valid gating and the output register.

Test Plan:
- ADD: opcode 0110011, f3 000, f7_5 0 -> next cycle RW1 AS0 MR0 MW0 M2R0 BR0 ALUOp10, Illegal0.
- LW: opcode 0000011, f3 010, f7_5 X -> RW1 AS1 MR1 MW0 M2R1 BR0 ALUOp00, with no X on any output.
- BEQ: opcode 1100011, f3 000, f7_5 X -> RW0 AS0 MR0 MW0 M2R0 BR1 ALUOp01.
- SW: opcode 0100011, f3 010, f7_5 X -> RW0 AS1 MR0 MW1 M2R0 BR0 ALUOp00.
- Illegal cases: opcode 1111111, then R-type f3 001 with f7_5 1, then LW with f3 000 -> each gives all strobes 0 and Illegal 1.
- Reset and valid gating:
  - assert rst while ADD is presented with valid_in 1 -> outputs 0;
  - deassert rst with valid_in 0 -> NOP with valid_out 0;
  - issue ADD, LW, BEQ, SW back-to-back -> outputs track each instruction one cycle later.

Source files
------------

// File: rtl/rv_main_control_pkg.sv
// rv_pkg: shared definitions for the RV32I-subset main-control decoder.
//   - Opcode constants for the supported instruction formats.
//   - ALUOp encodings handed to the downstream ALU-control block.
//   - ctrl_t: the seven datapath control fields as one packed bundle.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   reg_write;
    logic   alu_src;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    logic   branch;
    aluop_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    alu_src:    1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    branch:     1'b0,
    alu_op:     ALUOP_ADD
  };

endpackage

// File: rtl/rv_main_control_decode.sv
// rv_ctrl_decode_comb: purely combinational main-control decode and
// legality check.
//   opcode   in  7  instr[6:0]
//   funct3   in  3  instr[14:12]
//   funct7_5 in  1  instr[30]; only consulted for R-type and I-ALU
//   ctrl     out    decoded control bundle (NOP when illegal)
//   illegal  out 1  encoding is unsupported or illegal
module rv_ctrl_decode_comb
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl,
  output logic       illegal
);

  ctrl_t dec;

  // funct7_5 is read only inside the R-type and I-ALU arms, so an X on it
  // for load/store/branch cannot propagate into the decode.
  always_comb begin
    dec     = CTRL_NOP;
    illegal = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_R;
        // funct7_5 = 1 only encodes SUB (000) and SRA (101).
        if (funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101))
          illegal = 1'b1;
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALUOP_I;
        // SLLI must carry funct7_5 = 0; SRLI/SRAI accept either value.
        if ((funct3 == 3'b001) && funct7_5)
          illegal = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_op     = ALUOP_ADD;
        if (funct3 != 3'b010)
          illegal = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALUOP_ADD;
        if (funct3 != 3'b010)
          illegal = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_BR;
        if ((funct3 == 3'b010) || (funct3 == 3'b011))
          illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign ctrl = illegal ? CTRL_NOP : dec;

endmodule

// File: rtl/rv_main_control.sv
// rv_main_control: registered main-control decoder for an RV32I-subset core.
// Outputs reflect the instruction presented one rising edge earlier.
//   clk       in  1  clock, rising edge
//   rst       in  1  synchronous active-high reset
//   valid_in  in  1  instruction fields valid this cycle
//   opcode    in  7  instr[6:0]
//   funct3    in  3  instr[14:12]
//   funct7_5  in  1  instr[30]
//   RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch  out 1  strobes
//   ALUOp     out 2  00 add, 01 branch cmp, 10 R decode, 11 I decode
//   Illegal   out 1  unsupported/illegal encoding (strobes forced to 0)
//   valid_out out 1  registered valid_in
module rv_main_control
  import rv_pkg::*;
#(
  parameter logic [1:0] RESET_ALUOP = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic       Illegal,
  output logic       valid_out
);

  ctrl_t dec_ctrl;
  logic  dec_illegal;

  rv_ctrl_decode_comb u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      ALUSrc    <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      MemtoReg  <= 1'b0;
      Branch    <= 1'b0;
      ALUOp     <= RESET_ALUOP;
      Illegal   <= 1'b0;
      valid_out <= 1'b0;
    end else if (!valid_in) begin
      RegWrite  <= 1'b0;
      ALUSrc    <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      MemtoReg  <= 1'b0;
      Branch    <= 1'b0;
      ALUOp     <= ALUOP_ADD;
      Illegal   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      // dec_ctrl is already the NOP bundle when dec_illegal is set.
      RegWrite  <= dec_ctrl.reg_write;
      ALUSrc    <= dec_ctrl.alu_src;
      MemRead   <= dec_ctrl.mem_read;
      MemWrite  <= dec_ctrl.mem_write;
      MemtoReg  <= dec_ctrl.mem_to_reg;
      Branch    <= dec_ctrl.branch;
      ALUOp     <= dec_ctrl.alu_op;
      Illegal   <= dec_illegal;
      valid_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_main_control.sv
// Directed bench for rv_main_control. Each step drives one instruction on
// the falling edge and checks the registered bundle just after the next
// rising edge. Bundle order: RW AS MR MW M2R BR ALUOp[1:0] Illegal valid_out.
module tb_rv_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch;
  logic [1:0] ALUOp;
  logic       Illegal, valid_out;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  rv_main_control #(.RESET_ALUOP(2'b00)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .RegWrite  (RegWrite),
    .ALUSrc    (ALUSrc),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemtoReg  (MemtoReg),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .Illegal   (Illegal),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] E_ZERO  = 10'b0_0_0_0_0_0_00_0_0;
  localparam logic [9:0] E_RTYPE = 10'b1_0_0_0_0_0_10_0_1;
  localparam logic [9:0] E_IALU  = 10'b1_1_0_0_0_0_11_0_1;
  localparam logic [9:0] E_LOAD  = 10'b1_1_1_0_1_0_00_0_1;
  localparam logic [9:0] E_STORE = 10'b0_1_0_1_0_0_00_0_1;
  localparam logic [9:0] E_BR    = 10'b0_0_0_0_0_1_01_0_1;
  localparam logic [9:0] E_ILL   = 10'b0_0_0_0_0_0_00_1_1;

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic [9:0] exp);
    logic [9:0] obs;
    @(negedge clk);
    rst      = r;
    valid_in = v;
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
    @(posedge clk);
    #1;
    obs = {RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch,
           ALUOp, Illegal, valid_out};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;

    // Reset wins over a valid ADD, then release with no instruction.
    step("rst_over_add",  1'b1, 1'b1, 7'b0110011, 3'b000, 1'b0, E_ZERO);
    step("nop_after_rst", 1'b0, 1'b0, 7'b0110011, 3'b000, 1'b0, E_ZERO);

    // Back-to-back ADD, LW, BEQ, SW with X on funct7_5 where not used.
    step("add",   1'b0, 1'b1, 7'b0110011, 3'b000, 1'b0, E_RTYPE);
    step("lw",    1'b0, 1'b1, 7'b0000011, 3'b010, 1'bx, E_LOAD);
    step("beq",   1'b0, 1'b1, 7'b1100011, 3'b000, 1'bx, E_BR);
    step("sw",    1'b0, 1'b1, 7'b0100011, 3'b010, 1'bx, E_STORE);

    // Illegal encodings.
    step("op_7f",       1'b0, 1'b1, 7'b1111111, 3'b000, 1'b0, E_ILL);
    step("r_f3_1_f7_1", 1'b0, 1'b1, 7'b0110011, 3'b001, 1'b1, E_ILL);
    step("lw_f3_0",     1'b0, 1'b1, 7'b0000011, 3'b000, 1'bx, E_ILL);
    step("sw_f3_1",     1'b0, 1'b1, 7'b0100011, 3'b001, 1'bx, E_ILL);
    step("br_f3_2",     1'b0, 1'b1, 7'b1100011, 3'b010, 1'bx, E_ILL);
    step("br_f3_3",     1'b0, 1'b1, 7'b1100011, 3'b011, 1'bx, E_ILL);
    step("slli_f7_1",   1'b0, 1'b1, 7'b0010011, 3'b001, 1'b1, E_ILL);
    step("op_zero",     1'b0, 1'b1, 7'b0000000, 3'b000, 1'b0, E_ILL);

    // Legal funct7_5 corner cases.
    step("sub",       1'b0, 1'b1, 7'b0110011, 3'b000, 1'b1, E_RTYPE);
    step("sra",       1'b0, 1'b1, 7'b0110011, 3'b101, 1'b1, E_RTYPE);
    step("xor",       1'b0, 1'b1, 7'b0110011, 3'b100, 1'b0, E_RTYPE);
    step("addi",      1'b0, 1'b1, 7'b0010011, 3'b000, 1'b0, E_IALU);
    step("ori_f7_1",  1'b0, 1'b1, 7'b0010011, 3'b110, 1'b1, E_IALU);
    step("slli",      1'b0, 1'b1, 7'b0010011, 3'b001, 1'b0, E_IALU);
    step("srai",      1'b0, 1'b1, 7'b0010011, 3'b101, 1'b1, E_IALU);
    step("srli",      1'b0, 1'b1, 7'b0010011, 3'b101, 1'b0, E_IALU);
    step("blt",       1'b0, 1'b1, 7'b1100011, 3'b100, 1'bx, E_BR);
    step("bgeu",      1'b0, 1'b1, 7'b1100011, 3'b111, 1'bx, E_BR);

    // valid_in low masks even an illegal opcode.
    step("gated_ill", 1'b0, 1'b0, 7'b1111111, 3'b000, 1'b0, E_ZERO);
    step("gated_lw",  1'b0, 1'b0, 7'b0000011, 3'b010, 1'bx, E_ZERO);

    // Mid-stream reset discards the instruction presented with it.
    step("lw_again",  1'b0, 1'b1, 7'b0000011, 3'b010, 1'bx, E_LOAD);
    step("rst_mid",   1'b1, 1'b1, 7'b0100011, 3'b010, 1'bx, E_ZERO);
    step("rst_ill",   1'b1, 1'b1, 7'b1111111, 3'b000, 1'b0, E_ZERO);
    step("post_rst",  1'b0, 1'b0, 7'b0000000, 3'b000, 1'b0, E_ZERO);
    step("add_final", 1'b0, 1'b1, 7'b0110011, 3'b000, 1'b0, E_RTYPE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
